// File: rtl/pipeline_types.sv
// Shared pipeline types for the id -> dispatch -> execute path.
// Optional statistics build macro: DISPATCH_QUEUE_STATS_EN.
package pipeline_types;

   // Decoded instruction as it leaves the id/dispatch register
   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
      logic [5:0]  op;
      logic [4:0]  rd;
      logic        rd_we;
   } id_dispatch_t;

   // Pipeline control bundle driven by the hazard/pause logic
   typedef struct packed {
      logic pause;
      logic branch_flush;
      logic exception_flush;
   } ctrl_t;

   localparam int DISPATCH_QUEUE_DEPTH = 4;

`ifdef DISPATCH_QUEUE_STATS_EN
   // Observability counters for the dispatch queue
   typedef struct packed {
      logic [31:0] stall_cycles;
      logic [31:0] flushed_entries;
   } dispatch_queue_stats_t;
`endif

   // Saturating 32-bit add so counters stick at all-ones instead of wrapping
   function automatic logic [31:0] satAdd32(input logic [31:0] a, input logic [31:0] b);
      logic [32:0] sum;
      sum = {1'b0, a} + {1'b0, b};
      return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
   endfunction

endpackage

// File: rtl/dispatch_queue.sv
// dispatch_queue: small in-order first-word-fall-through queue between the
// id/dispatch register and the execute stage. Requests an upstream pause
// when full and discards everything on a branch or exception flush.
// Optional statistics outputs are enabled with DISPATCH_QUEUE_STATS_EN.
module dispatch_queue
   import pipeline_types::*;
#(
   parameter int DEPTH = DISPATCH_QUEUE_DEPTH
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       branch_flush,
   input  logic                       exception_flush,
   input  logic                       pause_ex_i,
   input  id_dispatch_t               dispatch_i,
   input  logic                       dispatch_valid_i,
   output logic                       pause_request_o,
   output id_dispatch_t               issue_o,
   output logic                       issue_valid_o,
   output logic [$clog2(DEPTH):0]     count_o
`ifdef DISPATCH_QUEUE_STATS_EN
   ,
   output logic [31:0]                stall_cycles_o,
   output logic [31:0]                flushed_entries_o
`endif
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [PTR_W-1:0] r_wrPtr;
   logic [PTR_W-1:0] r_rdPtr;
   logic [PTR_W:0]   r_count;
   id_dispatch_t     r_mem [DEPTH];

   logic w_full;
   logic w_empty;
   logic w_flush;
   logic w_push;
   logic w_pop;
   logic w_issueValid;

   // Status and handshake terms; pause request depends only on stored state
   assign w_full       = (r_count == (PTR_W+1)'(DEPTH));
   assign w_empty      = (r_count == '0);
   assign w_flush      = branch_flush || exception_flush;
   assign w_issueValid = !w_empty && !w_flush;
   assign w_push       = dispatch_valid_i && !w_full && !w_flush;
   assign w_pop        = w_issueValid && !pause_ex_i;

   assign pause_request_o = w_full;
   assign issue_valid_o   = w_issueValid;
   assign issue_o         = w_issueValid ? r_mem[r_rdPtr] : '0;
   assign count_o         = r_count;

   // Pointer and occupancy tracking; a flush collapses the queue to empty
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else if (w_flush) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_push) begin
            r_wrPtr <= r_wrPtr + PTR_W'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + PTR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (PTR_W+1)'(1);
            2'b01:   r_count <= r_count - (PTR_W+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Entry storage is written on push only and deliberately has no reset
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wrPtr] <= dispatch_i;
      end
   end

`ifdef DISPATCH_QUEUE_STATS_EN
   dispatch_queue_stats_t r_stats;

   // Saturating counters for upstream stalls and entries thrown away by flushes
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_stats <= '0;
      end else begin
         if (w_full && dispatch_valid_i) begin
            r_stats.stall_cycles <= satAdd32(r_stats.stall_cycles, 32'd1);
         end
         if (w_flush) begin
            r_stats.flushed_entries <= satAdd32(r_stats.flushed_entries, 32'(r_count));
         end
      end
   end

   assign stall_cycles_o    = r_stats.stall_cycles;
   assign flushed_entries_o = r_stats.flushed_entries;
`endif

endmodule

// File: tb/tb_dispatch_queue.sv
// Testbench for dispatch_queue: directed stimulus with a queue-based
// reference model compared every cycle, plus literal spot checks.
// Build with DISPATCH_QUEUE_STATS_EN to also cover the statistics outputs.
module tb_dispatch_queue;
   import pipeline_types::*;

   localparam int DEPTH = 4;

   logic         clk;
   logic         rst;
   logic         branch_flush;
   logic         exception_flush;
   logic         pause_ex_i;
   id_dispatch_t dispatch_i;
   logic         dispatch_valid_i;
   logic         pause_request_o;
   id_dispatch_t issue_o;
   logic         issue_valid_o;
   logic [2:0]   count_o;
`ifdef DISPATCH_QUEUE_STATS_EN
   logic [31:0]  stall_cycles_o;
   logic [31:0]  flushed_entries_o;
`endif

   int assertCount = 0;
   int failCount   = 0;
   bit checkEn     = 0;

   dispatch_queue #(.DEPTH(DEPTH)) dut (
      .clk              (clk),
      .rst              (rst),
      .branch_flush     (branch_flush),
      .exception_flush  (exception_flush),
      .pause_ex_i       (pause_ex_i),
      .dispatch_i       (dispatch_i),
      .dispatch_valid_i (dispatch_valid_i),
      .pause_request_o  (pause_request_o),
      .issue_o          (issue_o),
      .issue_valid_o    (issue_valid_o),
      .count_o          (count_o)
`ifdef DISPATCH_QUEUE_STATS_EN
      ,
      .stall_cycles_o   (stall_cycles_o),
      .flushed_entries_o(flushed_entries_o)
`endif
   );

   // Free-running clock, period 10
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Build a recognisable entry from an index
   function automatic id_dispatch_t mk(input int idx);
      id_dispatch_t e;
      e.pc    = 32'h1000 + 32'(idx) * 32'd4;
      e.instr = 32'hA000_0000 | 32'(idx);
      e.op    = 6'(idx);
      e.rd    = 5'(idx + 1);
      e.rd_we = idx[0];
      return e;
   endfunction

   // Reference model state: the queue contents in order, plus statistics
   id_dispatch_t mq[$];
   logic [31:0]  mStall;
   logic [31:0]  mFlushed;
   bit           mF;
   bit           mFull;
   bit           mPush;
   bit           mPop;
   id_dispatch_t mDrop;

   // Model update at each edge from the rules: flush empties, else pop head / append
   always @(posedge clk or posedge rst) begin
      if (rst) begin
         mq.delete();
         mStall   = '0;
         mFlushed = '0;
      end else begin
         mF    = branch_flush || exception_flush;
         mFull = (mq.size() == DEPTH);
         mPop  = (mq.size() != 0) && !mF && !pause_ex_i;
         mPush = dispatch_valid_i && !mFull && !mF;
         if (mFull && dispatch_valid_i) mStall = satAdd32(mStall, 32'd1);
         if (mF) mFlushed = satAdd32(mFlushed, 32'(mq.size()));
         if (mF) begin
            mq.delete();
         end else begin
            if (mPop) mDrop = mq.pop_front();
            if (mPush) mq.push_back(dispatch_i);
         end
      end
   end

   task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
      assertCount++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle compare of all outputs against the model, away from the active edge
   always @(negedge clk) begin
      if (checkEn && !rst) begin
         bit           eValid;
         id_dispatch_t eIssue;
         eValid = (mq.size() != 0) && !(branch_flush || exception_flush);
         eIssue = eValid ? mq[0] : '0;
         checkOutput("model_valid", 128'(issue_valid_o), 128'(eValid));
         checkOutput("model_issue", 128'(issue_o), 128'(eIssue));
         checkOutput("model_pause", 128'(pause_request_o), 128'(mq.size() == DEPTH));
         checkOutput("model_count", 128'(count_o), 128'(mq.size()));
`ifdef DISPATCH_QUEUE_STATS_EN
         checkOutput("model_stall", 128'(stall_cycles_o), 128'(mStall));
         checkOutput("model_flushed", 128'(flushed_entries_o), 128'(mFlushed));
`endif
      end
   end

   // One cycle: drive after the edge, return at the following falling edge
   task automatic applyStimulus(input logic v, input id_dispatch_t d, input logic p,
                                input logic bf, input logic ef);
      @(posedge clk);
      #1;
      dispatch_valid_i = v;
      dispatch_i       = d;
      pause_ex_i       = p;
      branch_flush     = bf;
      exception_flush  = ef;
      @(negedge clk);
   endtask

   task automatic loadThree();
      applyStimulus(1'b1, mk(13), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, mk(14), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, mk(15), 1'b1, 1'b0, 1'b0);
   endtask

   // Directed sequence with hand-computed literal expectations
   initial begin
      rst              = 1'b1;
      branch_flush     = 1'b0;
      exception_flush  = 1'b0;
      pause_ex_i       = 1'b0;
      dispatch_i       = '0;
      dispatch_valid_i = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst     = 1'b0;
      checkEn = 1'b1;

      // Idle after reset
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
         checkOutput("idle_valid", 128'(issue_valid_o), 128'(0));
         checkOutput("idle_issue", 128'(issue_o), 128'(0));
         checkOutput("idle_pause", 128'(pause_request_o), 128'(0));
         checkOutput("idle_count", 128'(count_o), 128'(0));
      end

      // Fill A..D with execute stalled
      applyStimulus(1'b1, mk(0), 1'b1, 1'b0, 1'b0);
      checkOutput("fill_first_latency", 128'(issue_valid_o), 128'(0));
      applyStimulus(1'b1, mk(1), 1'b1, 1'b0, 1'b0);
      checkOutput("fill_head_a", 128'(issue_o.pc), 128'(32'h1000));
      applyStimulus(1'b1, mk(2), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, mk(3), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b1, mk(4), 1'b1, 1'b0, 1'b0);
         checkOutput("full_count", 128'(count_o), 128'(4));
         checkOutput("full_pause", 128'(pause_request_o), 128'(1));
         checkOutput("full_head", 128'(issue_o.pc), 128'(32'h1000));
      end

      // Drain A..D, E enters once there is room
      applyStimulus(1'b1, mk(4), 1'b0, 1'b0, 1'b0);
      checkOutput("drain_a", 128'(issue_o.pc), 128'(32'h1000));
      checkOutput("drain_a_pause", 128'(pause_request_o), 128'(1));
      applyStimulus(1'b1, mk(4), 1'b0, 1'b0, 1'b0);
      checkOutput("drain_b", 128'(issue_o.pc), 128'(32'h1004));
      checkOutput("drain_b_pause", 128'(pause_request_o), 128'(0));
      checkOutput("drain_b_count", 128'(count_o), 128'(3));
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("drain_c", 128'(issue_o.pc), 128'(32'h1008));
      checkOutput("drain_c_count", 128'(count_o), 128'(3));
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("drain_d", 128'(issue_o.pc), 128'(32'h100C));
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("drain_e", 128'(issue_o.pc), 128'(32'h1010));
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("drain_empty", 128'(issue_valid_o), 128'(0));
`ifdef DISPATCH_QUEUE_STATS_EN
      checkOutput("stats_stall", 128'(stall_cycles_o), 128'(4));
`endif

      // Simultaneous push and pop at count 2, wrapping the pointers
      applyStimulus(1'b1, mk(5), 1'b1, 1'b0, 1'b0);
      applyStimulus(1'b1, mk(6), 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         applyStimulus(1'b1, mk(7 + i), 1'b0, 1'b0, 1'b0);
         checkOutput("pushpop_count", 128'(count_o), 128'(2));
         checkOutput("pushpop_head", 128'(issue_o.pc), 128'(32'h1014 + 32'(i) * 32'd4));
      end
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("pushpop_tail1", 128'(issue_o.pc), 128'(32'h102C));
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("pushpop_tail2", 128'(issue_o.pc), 128'(32'h1030));
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);

      // Flush from each source and from both together
      for (int k = 1; k <= 3; k++) begin
         loadThree();
         applyStimulus(1'b1, mk(20), 1'b0, k[0], k[1]);
         checkOutput("flush_valid", 128'(issue_valid_o), 128'(0));
         checkOutput("flush_issue", 128'(issue_o), 128'(0));
         checkOutput("flush_count_before", 128'(count_o), 128'(3));
         applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
         checkOutput("flush_count_after", 128'(count_o), 128'(0));
         checkOutput("flush_g_absent", 128'(issue_valid_o), 128'(0));
      end
`ifdef DISPATCH_QUEUE_STATS_EN
      checkOutput("stats_flushed", 128'(flushed_entries_o), 128'(9));
`endif

      // Asynchronous reset between edges
      loadThree();
      applyStimulus(1'b0, '0, 1'b1, 1'b0, 1'b0);
      checkOutput("prereset_count", 128'(count_o), 128'(3));
      #1;
      rst = 1'b1;
      #1;
      checkOutput("areset_valid", 128'(issue_valid_o), 128'(0));
      checkOutput("areset_issue", 128'(issue_o), 128'(0));
      checkOutput("areset_pause", 128'(pause_request_o), 128'(0));
      checkOutput("areset_count", 128'(count_o), 128'(0));
`ifdef DISPATCH_QUEUE_STATS_EN
      checkOutput("areset_stall", 128'(stall_cycles_o), 128'(0));
`endif
      @(posedge clk);
      #1;
      rst = 1'b0;
      applyStimulus(1'b0, '0, 1'b0, 1'b0, 1'b0);
      checkOutput("postreset_count", 128'(count_o), 128'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
